axi_fmap_writer: RTL and testbench
==================================

# axi_fmap_writer

AXI4-Lite-style write master that drains a stream of signed 8-bit layer outputs (feature-map activations) and stores them one element per 32-bit word into AXI-MM memory. It is the write-direction counterpart of the weight/bias read loader. It sits between a conv/dense layer output stream and the shared memory slave, so downstream layers or the host can read results back. Exactly one write transaction is outstanding at a time.

## Interface
Parameters:
- OUT_COUNT, 18928: elements to write per run (26×26×28 first-conv output).
- BASE_ADDR, 32'h0000_0000: byte address of element 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begins a run; ignored while busy=1.
- busy  out  1  high from accepted start until the final B response.
- done  out  1  high after a run completes; cleared when the next start is accepted.
- err  out  1  sticky; set on any BRESP≠2'b00 in a run; cleared on start.
- S_VALID  in  1  activation valid.
- S_READY  out  1  activation accepted when S_VALID&&S_READY.
- S_DATA  in  8  signed activation.
- M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  write-address handshake.
- M_AXI_AWADDR  out  32  BASE_ADDR + 4*index.
- M_AXI_WVALID / M_AXI_WREADY  out/in  1  write-data handshake.
- M_AXI_WDATA  out  32  S_DATA sign-extended to 32 bits.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_BVALID / M_AXI_BREADY  in/out  1  write-response handshake.
- M_AXI_BRESP  in  2  response code.

## Operation
- FSM states: IDLE, GET, XFER, RESP.
- IDLE: busy=0, S_READY=0. On start: index←0, err←0, done←0, go to GET.
- GET: S_READY=1. On an S_VALID&&S_READY beat: latch sign-extended data into the WDATA register, latch AWADDR=BASE_ADDR+{index,2'b00}, go to XFER.
- XFER: AWVALID and WVALID are both asserted together. Each valid drops independently on its own handshake; one may complete before the other, and both may complete in the same cycle. When both are done, go to RESP.
- RESP: BREADY=1. On BVALID: if BRESP≠0, set err. If index==OUT_COUNT-1, set done, clear busy, go to IDLE. Otherwise index←index+1 and go to GET.
- The index counter is $clog2(OUT_COUNT) bits wide. Address arithmetic is 32-bit and wraps modulo 2^32 without a flag.
- AWADDR and WDATA are held stable while their valid is high.
- A start pulse that arrives during busy has no effect.
- Reset mid-run: all state returns to IDLE immediately. The partially written run is abandoned, and no AXI valid remains high after reset.

## Timing
- Reset values: AWVALID=0, WVALID=0, BREADY=0, S_READY=0, busy=0, done=0, err=0, AWADDR=0, WDATA=0.
- start accepted at edge N: busy=1 and S_READY=1 from cycle N+1.
- Stream beat at edge M: AWVALID and WVALID=1 from cycle M+1. S_READY=0 from M+1 until the next GET.
- Zero-wait slave (AWREADY=WREADY=1, BVALID one cycle after the W handshake): 4 cycles per element (GET, XFER, RESP with BVALID wait, RESP accept). Minimum steady state: 3 cycles per element with an always-valid stream and BVALID returned combinationally in the first RESP cycle.
- done rises the cycle after the final B handshake; busy falls on the same cycle.
- BVALID arriving outside RESP is not accepted, because BREADY=0.

## Test plan
- Basic run, OUT_COUNT=8, BASE_ADDR=0x100, stream −4..3, zero-wait slave -> memory words 0x100..0x11C hold FFFFFFFC, FFFFFFFD, FFFFFFFE, FFFFFFFF, 0, 1, 2, 3; done=1; err=0; exactly 8 AW, 8 W and 8 B handshakes.
- Skewed handshakes: AWREADY delayed 3 cycles while WREADY is immediate, then the reverse; then both ready in the same cycle -> each valid drops exactly at its own handshake; data is unchanged; no duplicate writes.
- Backpressure and bubbles: S_VALID randomly low 50% of cycles; BVALID delayed 0–5 cycles -> all 784 values (OUT_COUNT=784) match a golden model; S_READY never high outside GET.
- Error response: slave returns BRESP=2'b10 on element 5 of 8 -> err=1 and stays high; the run still completes all 8 writes; the next start clears err.
- Reset mid-run: assert rst_n=0 while AWVALID=1 at element 3 -> all outputs take their reset values within the same cycle. A new start then rewrites from BASE_ADDR with index 0.
- start during busy: pulse start at element 2 -> no restart; the address sequence is continuous; done asserts once.

Source files
------------

// File: rtl/axi_fmap_writer_if.sv
// rtl/axi_fmap_writer_if.sv - activation stream in, AXI4-Lite write channels out
interface axi_fmap_writer_if;
    logic        S_VALID;
    logic        S_READY;
    logic [7:0]  S_DATA;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [1:0]  M_AXI_BRESP;

    modport master (
        input  S_VALID, S_DATA,
        output S_READY,
        output M_AXI_AWVALID, M_AXI_AWADDR,
        input  M_AXI_AWREADY,
        output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID, M_AXI_BRESP,
        output M_AXI_BREADY
    );

    modport slave (
        output S_VALID, S_DATA,
        input  S_READY,
        input  M_AXI_AWVALID, M_AXI_AWADDR,
        output M_AXI_AWREADY,
        input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        output M_AXI_WREADY,
        output M_AXI_BVALID, M_AXI_BRESP,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/axi_fmap_writer.sv
// rtl/axi_fmap_writer.sv - drains signed 8-bit activations into one 32-bit AXI word each
module axi_fmap_writer #(
    parameter int          OUT_COUNT = 18928,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    axi_fmap_writer_if.master  bus
);
    localparam int IDX_W = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_COUNT - 1);

    typedef enum logic [1:0] {IDLE, GET, XFER, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = GET;
                end
            end
            GET: begin
                if (bus.S_VALID) begin
                    wdata_d   = {{24{bus.S_DATA[7]}}, bus.S_DATA};
                    awaddr_d  = BASE_ADDR + (32'(idx_q) << 2);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = XFER;
                end
            end
            XFER: begin
                // Address and data channels retire independently, possibly together.
                if (awvalid_q && bus.M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && bus.M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)        state_d   = RESP;
            end
            RESP: begin
                if (bus.M_AXI_BVALID) begin
                    if (bus.M_AXI_BRESP != 2'b00) err_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = GET;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign bus.S_READY       = (state_q == GET);
    assign bus.M_AXI_BREADY  = (state_q == RESP);
    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_AWADDR  = awaddr_q;
    assign bus.M_AXI_WVALID  = wvalid_q;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = 4'hF;
endmodule

// File: tb/tb_axi_fmap_writer.sv
// tb/tb_axi_fmap_writer.sv - randomized bench for axi_fmap_writer against a transaction-count model
module tb_axi_fmap_writer;
    localparam int          OUT  = 8;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err;

    axi_fmap_writer_if bus ();

    axi_fmap_writer #(.OUT_COUNT(OUT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: a run is described purely by how many transfers of each kind have happened.
    bit run_active, done_exp, err_exp, started;
    int beats, aw_n, w_n, b_n;
    logic [7:0]  src[$];
    logic [7:0]  sent[$];
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    logic [31:0] mem [logic [31:0]];
    int err_at, aw_cfg, w_cfg, b_min, b_max, sv_pct;
    int aw_wait, w_wait, b_wait;
    bit b_armed, spurious, start_req;
    bit prev_aw_hold, prev_w_hold;
    logic [31:0] prev_awaddr, prev_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [7:0] d);
        return {{24{d[7]}}, d};
    endfunction

    function automatic int pick(input int cfg, input int mx);
        return (cfg < 0) ? int'($urandom_range(mx)) : cfg;
    endfunction

    task automatic clear_model();
        run_active = 0; done_exp = 0; err_exp = 0;
        beats = 0; aw_n = 0; w_n = 0; b_n = 0;
        sent.delete(); aw_log.delete(); w_log.delete();
        b_armed = 0; prev_aw_hold = 0; prev_w_hold = 0;
    endtask

    task automatic step();
        bit pending, s_hs, aw_hs, w_hs, b_hs, st_hs;
        @(negedge clk);
        chk("busy",    32'(busy),    32'(run_active));
        chk("done",    32'(done),    32'(done_exp));
        chk("err",     32'(err),     32'(err_exp));
        chk("s_ready", 32'(bus.S_READY), 32'(run_active && beats == b_n && beats < OUT));
        chk("awvalid", 32'(bus.M_AXI_AWVALID), 32'(beats > aw_n));
        chk("wvalid",  32'(bus.M_AXI_WVALID),  32'(beats > w_n));
        chk("bready",  32'(bus.M_AXI_BREADY),
            32'(run_active && aw_n == beats && w_n == beats && b_n < beats));
        if (prev_aw_hold) chk("awaddr_stable", bus.M_AXI_AWADDR, prev_awaddr);
        if (prev_w_hold)  chk("wdata_stable",  bus.M_AXI_WDATA,  prev_wdata);
        if (bus.M_AXI_AWVALID) chk("awaddr", bus.M_AXI_AWADDR, BASE + 32'(4 * aw_n));
        if (bus.M_AXI_WVALID && w_n < sent.size()) chk("wdata", bus.M_AXI_WDATA, sext(sent[w_n]));
        if (bus.M_AXI_WVALID) chk("wstrb", 32'(bus.M_AXI_WSTRB), 32'hF);

        start = start_req;
        start_req = 0;
        if (src.size() > 0 && int'($urandom_range(99)) < sv_pct) begin
            bus.S_VALID = 1'b1;
            bus.S_DATA  = src[0];
        end else begin
            bus.S_VALID = 1'b0;
            bus.S_DATA  = 8'($urandom);
        end
        if (bus.M_AXI_AWVALID) begin
            if (aw_wait > 0) begin bus.M_AXI_AWREADY = 1'b0; aw_wait--; end
            else bus.M_AXI_AWREADY = 1'b1;
        end else bus.M_AXI_AWREADY = spurious ? 1'($urandom_range(1)) : 1'b0;
        if (bus.M_AXI_WVALID) begin
            if (w_wait > 0) begin bus.M_AXI_WREADY = 1'b0; w_wait--; end
            else bus.M_AXI_WREADY = 1'b1;
        end else bus.M_AXI_WREADY = spurious ? 1'($urandom_range(1)) : 1'b0;
        pending = (aw_n > b_n) && (w_n > b_n);
        if (pending && b_armed) begin
            bus.M_AXI_BVALID = 1'b1;
        end else if (pending) begin
            if (b_wait > 0) begin bus.M_AXI_BVALID = 1'b0; b_wait--; end
            else begin
                bus.M_AXI_BVALID = 1'b1;
                bus.M_AXI_BRESP  = (b_n == err_at) ? 2'b10 : 2'b00;
            end
        end else begin
            // Stray responses carry an error code so any wrongful acceptance shows up on err.
            bus.M_AXI_BVALID = spurious ? 1'($urandom_range(1)) : 1'b0;
            bus.M_AXI_BRESP  = 2'b10;
        end

        s_hs  = bus.S_VALID && bus.S_READY;
        aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
        w_hs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
        b_hs  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
        st_hs = start && !busy;
        b_armed      = pending && bus.M_AXI_BVALID && !b_hs;
        prev_aw_hold = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
        prev_w_hold  = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
        prev_awaddr  = bus.M_AXI_AWADDR;
        prev_wdata   = bus.M_AXI_WDATA;
        if (s_hs) begin sent.push_back(src.pop_front()); beats++; end
        if (aw_hs) begin aw_log.push_back(bus.M_AXI_AWADDR); aw_n++; aw_wait = pick(aw_cfg, 3); end
        if (w_hs)  begin w_log.push_back(bus.M_AXI_WDATA);   w_n++;  w_wait = pick(w_cfg, 3); end
        if (b_hs) begin
            if (bus.M_AXI_BRESP != 2'b00) err_exp = 1;
            if (b_n < aw_log.size() && b_n < w_log.size()) mem[aw_log[b_n]] = w_log[b_n];
            b_n++;
            b_wait = b_min + int'($urandom_range(b_max - b_min));
            if (b_n == OUT) begin run_active = 0; done_exp = 1; end
        end
        if (st_hs) begin
            run_active = 1; done_exp = 0; err_exp = 0; started = 1;
            beats = 0; aw_n = 0; w_n = 0; b_n = 0;
            sent.delete(); aw_log.delete(); w_log.delete();
            aw_wait = pick(aw_cfg, 3); w_wait = pick(w_cfg, 3);
            b_wait = b_min + int'($urandom_range(b_max - b_min));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy",    32'(busy), 0);
        chk("rst_done",    32'(done), 0);
        chk("rst_err",     32'(err), 0);
        chk("rst_s_ready", 32'(bus.S_READY), 0);
        chk("rst_awvalid", 32'(bus.M_AXI_AWVALID), 0);
        chk("rst_wvalid",  32'(bus.M_AXI_WVALID), 0);
        chk("rst_bready",  32'(bus.M_AXI_BREADY), 0);
        chk("rst_awaddr",  bus.M_AXI_AWADDR, 0);
        chk("rst_wdata",   bus.M_AXI_WDATA, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        bus.S_VALID = 0; bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
        start = 0; src.delete(); clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Loads a stream, pulses start and steps until the run ends; mid_start re-pulses start while busy.
    task automatic run(input int mid_start);
        bit mid_done = 0;
        started = 0;
        mem.delete();
        start_req = 1;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (started && !run_active) break;
            if (mid_start >= 0 && !mid_done && beats == mid_start + 1) begin
                start_req = 1; mid_done = 1;
            end
        end
        chk("run_finished", 32'(started && !run_active), 1);
        chk("aw_count", 32'(aw_n), OUT);
        chk("w_count",  32'(w_n),  OUT);
        chk("b_count",  32'(b_n),  OUT);
        for (int k = 0; k < OUT; k++) begin
            logic [31:0] a, v;
            a = BASE + 32'(4 * k);
            v = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
            chk("mem_word", v, (k < sent.size()) ? sext(sent[k]) : 32'hBAD0_BAD0);
        end
        step();
        step();
    endtask

    task automatic cfg(input int aw, input int w, input int bmn, input int bmx,
                       input int pct, input bit spur, input int ea);
        aw_cfg = aw; w_cfg = w; b_min = bmn; b_max = bmx;
        sv_pct = pct; spurious = spur; err_at = ea;
    endtask

    logic [31:0] lit [8] = '{32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'h0, 32'h1, 32'h2, 32'h3};

    initial begin
        bus.S_VALID = 0; bus.S_DATA = 0;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0;
        bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
        clear_model();
        cfg(0, 0, 1, 1, 100, 0, -1);
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        step();

        // Basic run, zero-wait slave, stream -4..3.
        for (int k = 0; k < OUT; k++) src.push_back(8'(k - 4));
        run(-1);
        for (int k = 0; k < OUT; k++)
            chk("basic_literal", mem.exists(32'h100 + 32'(4 * k)) ? mem[32'h100 + 32'(4 * k)] : 32'hDEAD_BEEF, lit[k]);
        chk("basic_done", 32'(done), 1);
        chk("basic_err",  32'(err), 0);

        // Skewed handshakes: AW late, then W late, then both together.
        cfg(3, 0, 1, 1, 100, 0, -1);
        for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
        run(-1);
        cfg(0, 3, 1, 1, 100, 0, -1);
        for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
        run(-1);
        cfg(0, 0, 0, 0, 100, 0, -1);
        for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
        run(-1);

        // Error response on element 5, sticky through the run, cleared by the next start.
        cfg(0, 0, 1, 1, 100, 0, 5);
        for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
        run(-1);
        chk("err_sticky", 32'(err), 1);
        cfg(0, 0, 1, 1, 100, 0, -1);
        for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
        run(-1);
        chk("err_cleared", 32'(err), 0);

        // start during busy at element 2 must be ignored.
        for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
        run(2);

        // Reset mid-run while AWVALID is held at element 3, then a clean restart.
        cfg(3, 0, 1, 1, 100, 0, -1);
        for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
        started = 0;
        start_req = 1;
        for (int c = 0; c < 200; c++) begin
            step();
            if (beats == 4 && aw_n == 3) break;
        end
        @(negedge clk);
        chk("pre_reset_awvalid", 32'(bus.M_AXI_AWVALID), 1);
        do_reset();
        step();
        cfg(0, 0, 1, 1, 100, 0, -1);
        for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
        run(-1);

        // Randomized backpressure and bubbles: 98 runs x 8 = 784 elements.
        for (int r = 0; r < 98; r++) begin
            cfg(-1, -1, 0, 5, 50, 1, ($urandom_range(3) == 0) ? int'($urandom_range(OUT - 1)) : -1);
            for (int k = 0; k < OUT; k++) src.push_back(8'($urandom));
            run(-1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
